// File: rtl/proc_ctrl_fsm.sv
// Control FSM for the 8-register bus processor: IR, Tstep sequencing, strobes.
// Optional PROC_CTRL_RUN_EDGE_EN: fetch only on a rising edge of synced Run.
module proc_ctrl_fsm #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       Run,
    input  logic [7:0] DIN,
    output logic [7:0] IR,
    output logic [1:0] Tstep,
    output logic       IRin,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       DINout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       AddSub,
    output logic       Done
);

    typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;

    localparam logic [1:0] I_MV  = 2'b00;
    localparam logic [1:0] I_MVI = 2'b01;

    tstep_e                 state, state_nxt;
    logic [SYNC_STAGES-1:0] run_sync;
    logic                   run_s;
    logic                   fetch;
    logic [1:0]             op;
    logic [7:0]             x_hot, y_hot;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            run_sync <= '0;
        end else begin
            run_sync[0] <= Run;
            for (int i = 1; i < SYNC_STAGES; i++)
                run_sync[i] <= run_sync[i-1];
        end
    end

    assign run_s = run_sync[SYNC_STAGES-1];

`ifdef PROC_CTRL_RUN_EDGE_EN
    logic run_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) run_q <= 1'b0;
        else         run_q <= run_s;
    end

    assign fetch = run_s & ~run_q;
`else
    assign fetch = run_s;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= T0;
            IR    <= 8'h00;
        end else begin
            state <= state_nxt;
            if (IRin) IR <= DIN;
        end
    end

    assign op    = IR[1:0];
    assign x_hot = 8'd1 << IR[4:2];
    assign y_hot = 8'd1 << IR[7:5];
    assign Tstep = state;

    always_comb begin
        state_nxt = state;
        IRin      = 1'b0;
        Rin       = 8'h00;
        Rout      = 8'h00;
        DINout    = 1'b0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        Gout      = 1'b0;
        AddSub    = 1'b0;
        Done      = 1'b0;
        unique case (state)
            T0: begin
                IRin = fetch;
                if (fetch) state_nxt = T1;
            end
            T1: begin
                if (op == I_MV) begin
                    Rout      = y_hot;
                    Rin       = x_hot;
                    Done      = 1'b1;
                    state_nxt = T0;
                end else if (op == I_MVI) begin
                    DINout    = 1'b1;
                    Rin       = x_hot;
                    Done      = 1'b1;
                    state_nxt = T0;
                end else begin
                    Rout      = x_hot;
                    Ain       = 1'b1;
                    state_nxt = T2;
                end
            end
            T2: begin
                Rout      = y_hot;
                Gin       = 1'b1;
                AddSub    = op[0];
                state_nxt = T3;
            end
            T3: begin
                Gout      = 1'b1;
                Rin       = x_hot;
                Done      = 1'b1;
                state_nxt = T0;
            end
            default: state_nxt = T0;
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm: vector table plus reset/edge sequences.
module tb_proc_ctrl_fsm;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       Run;
    logic [7:0] DIN;
    logic [7:0] IR;
    logic [1:0] Tstep;
    logic       IRin;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       DINout, Ain, Gin, Gout, AddSub, Done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       run;
        logic [7:0] din;
        logic [1:0] ts;
        logic [7:0] ir;
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       dinout, ain, gin, gout, addsub, done;
    } vec_t;

    proc_ctrl_fsm #(.SYNC_STAGES(2)) dut (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .Run     (Run),
        .DIN     (DIN),
        .IR      (IR),
        .Tstep   (Tstep),
        .IRin    (IRin),
        .Rin     (Rin),
        .Rout    (Rout),
        .DINout  (DINout),
        .Ain     (Ain),
        .Gin     (Gin),
        .Gout    (Gout),
        .AddSub  (AddSub),
        .Done    (Done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic vec_t mk(
        input logic r, input logic [7:0] d, input logic [1:0] t,
        input logic [7:0] i, input logic f, input logic [7:0] ri,
        input logic [7:0] ro, input logic dn, input logic a,
        input logic g, input logic go, input logic s, input logic dd);
        vec_t v;
        v.run = r;   v.din = d;   v.ts = t;     v.ir = i;
        v.irin = f;  v.rin = ri;  v.rout = ro;  v.dinout = dn;
        v.ain = a;   v.gin = g;   v.gout = go;  v.addsub = s;
        v.done = dd;
        return v;
    endfunction

    function automatic logic [32:0] pack_exp(input vec_t v);
        return {v.ts, v.ir, v.irin, v.rin, v.rout,
                v.dinout, v.ain, v.gin, v.gout, v.addsub, v.done};
    endfunction

    function automatic logic [32:0] pack_act();
        return {Tstep, IR, IRin, Rin, Rout,
                DINout, Ain, Gin, Gout, AddSub, Done};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus_rules(input string name);
        int srcs;
        srcs = int'(Rout != 8'h00) + int'(DINout) + int'(Gout);
        chk({name, "_rout_onehot"}, 64'($countones(Rout) <= 1), 64'd1);
        chk({name, "_one_src"}, 64'(srcs <= 1), 64'd1);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic do_reset(input logic run_v, input logic [7:0] din_v);
        resetn = 1'b0;
        Run    = run_v;
        DIN    = din_v;
        tick();
        #1;
        resetn = 1'b1;
        #1;
    endtask

    vec_t vecs[18];

    initial begin
        int n;
        resetn = 1'b0;
        Run    = 1'b1;
        DIN    = 8'h44;
        #3;
        chk("reset_outputs", 64'(pack_act()), 64'd0);
        #9;
        resetn = 1'b1;

`ifndef PROC_CTRL_RUN_EDGE_EN
        //        run din    ts ir    irin rin   rout  dn a g go s d
        vecs[0]  = mk(1, 8'h44, 0, 8'h00, 0, 8'h00, 8'h00, 0,0,0,0,0,0);
        vecs[1]  = mk(1, 8'h44, 0, 8'h00, 0, 8'h00, 8'h00, 0,0,0,0,0,0);
        vecs[2]  = mk(1, 8'h44, 0, 8'h00, 1, 8'h00, 8'h00, 0,0,0,0,0,0);
        vecs[3]  = mk(1, 8'h44, 1, 8'h44, 0, 8'h02, 8'h04, 0,0,0,0,0,1);
        vecs[4]  = mk(1, 8'h0D, 0, 8'h44, 1, 8'h00, 8'h00, 0,0,0,0,0,0);
        vecs[5]  = mk(1, 8'h5A, 1, 8'h0D, 0, 8'h08, 8'h00, 1,0,0,0,0,1);
        vecs[6]  = mk(1, 8'hA2, 0, 8'h0D, 1, 8'h00, 8'h00, 0,0,0,0,0,0);
        vecs[7]  = mk(1, 8'hA2, 1, 8'hA2, 0, 8'h00, 8'h01, 0,1,0,0,0,0);
        vecs[8]  = mk(1, 8'hA2, 2, 8'hA2, 0, 8'h00, 8'h20, 0,0,1,0,0,0);
        vecs[9]  = mk(1, 8'hA2, 3, 8'hA2, 0, 8'h01, 8'h00, 0,0,0,1,0,1);
        vecs[10] = mk(1, 8'hFF, 0, 8'hA2, 1, 8'h00, 8'h00, 0,0,0,0,0,0);
        vecs[11] = mk(1, 8'hFF, 1, 8'hFF, 0, 8'h00, 8'h80, 0,1,0,0,0,0);
        vecs[12] = mk(1, 8'hFF, 2, 8'hFF, 0, 8'h00, 8'h80, 0,0,1,0,1,0);
        vecs[13] = mk(1, 8'hFF, 3, 8'hFF, 0, 8'h80, 8'h00, 0,0,0,1,0,1);
        vecs[14] = mk(0, 8'h00, 0, 8'hFF, 1, 8'h00, 8'h00, 0,0,0,0,0,0);
        vecs[15] = mk(0, 8'h00, 1, 8'h00, 0, 8'h01, 8'h01, 0,0,0,0,0,1);
        vecs[16] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0,0,0,0,0,0);
        vecs[17] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0,0,0,0,0,0);

        for (int i = 0; i < 18; i++) begin
            Run = vecs[i].run;
            DIN = vecs[i].din;
            #1;
            chk($sformatf("vec%0d", i), 64'(pack_act()),
                64'(pack_exp(vecs[i])));
            bus_rules($sformatf("vec%0d", i));
            tick();
        end

        // Asynchronous reset in T2 of an add must abort immediately.
        Run = 1'b1;
        DIN = 8'hA2;
        n = 0;
        while (Tstep != 2'd2 && n < 20) begin
            tick();
            n++;
        end
        chk("t2_reached", 64'(Tstep), 64'd2);
        chk("t2_gin", 64'(Gin), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_tstep", 64'(Tstep), 64'd0);
        chk("async_gin", 64'(Gin), 64'd0);
        chk("async_ir", 64'(IR), 64'd0);
        chk("async_all", 64'(pack_act()), 64'd0);
        Run = 1'b0;
        #3;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("idle%0d", i), 64'(pack_act()), 64'd0);
        end
`else
        // One instruction per rising edge of Run.
        resetn = 1'b0;
        #1;
        do_reset(1'b1, 8'h44);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            bus_rules($sformatf("edge_a%0d", i));
            if (Done) n++;
        end
        chk("edge_first_done", 64'(n), 64'd1);
        chk("edge_hold_t0", 64'(Tstep), 64'd0);
        chk("edge_ir", 64'(IR), 64'h44);
        Run = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Run = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Done) n++;
        end
        chk("edge_second_done", 64'(n), 64'd1);
        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("edge_idle%0d", i), 64'(pack_act()), 64'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
- Control unit for the 8-register, 8-bit bus processor datapath.
- Holds the instruction register and sequences the Tstep counter (T0..T3).
- Decodes I/X/Y fields and drives all bus-source and register-load strobes: IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub.
- Sits between the switch inputs (DIN, Run) and the regn/adder-subtractor/bus-mux datapath. It replaces ad-hoc step logic in the top level.

Parameters:
- SYNC_STAGES, default 2: flip-flop stages on the Run input (async switch). Minimum 1.

Ports:
- CLOCK_50  in   1  system clock, rising edge
- resetn    in   1  asynchronous, active-low reset
- Run       in   1  start/continue execution (raw switch level)
- DIN       in   8  instruction word, or immediate data for mvi
- IR        out  8  instruction register, for display
- Tstep     out  2  current step, 0..3
- IRin      out  1  IR load strobe (also drives the internal IR load)
- Rin       out  8  one-hot register load; bit k loads Rk
- Rout      out  8  one-hot register bus-drive select
- DINout    out  1  DIN drives bus
- Ain       out  1  load A register
- Gin       out  1  load G register
- Gout      out  1  G drives bus
- AddSub    out  1  0 = add, 1 = subtract
- Done      out  1  last step of the instruction

Behaviour:
- Encoding:
  - IR[1:0] = I: 00 mv, 01 mvi, 10 add, 11 sub.
  - IR[4:2] = X (destination).
  - IR[7:5] = Y (source).
- Run sync:
  - run_s is Run after SYNC_STAGES flops.
  - Adds SYNC_STAGES cycles of start latency.
- Registered state: Tstep (2 bits), IR (8 bits), sync flops.
- Outputs are combinational from Tstep, IR, run_s. Any strobe not listed in a step is 0.
- T0 (fetch):
  - IRin = run_s. IR <= DIN on the clock edge when IRin = 1.
  - If IRin: Tstep <= 1, else hold 0.
- T1:
  - mv: Rout[Y] = 1, Rin[X] = 1, Done = 1; Tstep <= 0.
  - mvi: DINout = 1, Rin[X] = 1, Done = 1; Tstep <= 0. The immediate is DIN sampled in this cycle.
  - add/sub: Rout[X] = 1, Ain = 1; Tstep <= 2.
- T2 (add/sub only):
  - Rout[Y] = 1, Gin = 1, AddSub = I[0]; Tstep <= 3.
- T3:
  - Gout = 1, Rin[X] = 1, Done = 1; Tstep <= 0.
- Latency:
  - mv/mvi: 2 cycles from fetch.
  - add/sub: 4 cycles from fetch.
  - Back-to-back execution while run_s = 1 (no idle cycle other than T0).
- X == Y is legal; e.g. mv R2,R2 asserts Rout[2] and Rin[2] together.
- Run deasserted mid-instruction: the current instruction completes. Only T0 checks run_s.
- At most one bit of Rout is set, and at most one of {Rout≠0, DINout, Gout} is active in any cycle. The verifier asserts both.
- Reset (resetn low, asynchronous):
  - Tstep = 0, IR = 0x00, sync flops = 0.
  - All outputs 0 immediately, including Done and Rin.
  - An in-flight instruction is aborted; no partial Rin is issued after release.
- After reset release: the first fetch occurs SYNC_STAGES cycles after run_s sees Run = 1.

Optional Feature:
- Macro: PROC_CTRL_RUN_EDGE_EN.
- Defined:
  - Adds flop run_q (reset 0), updated from run_s every cycle.
  - T0 fetches only when run_s & ~run_q, so exactly one instruction executes per rising edge of Run.
  - Run held high with IR-complete stays in T0.
  - A rising edge that arrives while not in T0 is lost.
- Undefined: level-sensitive fetch as described in Behaviour.

Test Plan:
1. Reset with Run = 1, release, DIN = 0x44 (mv R1,R2) → after 2 sync cycles IRin = 1. Next cycle Tstep = 1, IR = 0x44, Rout = 0x04, Rin = 0x02, Done = 1. Then Tstep = 0.
2. DIN = 0x0D (mvi R3), then DIN = 0x5A at T1 → T1: DINout = 1, Rin = 0x08, Done = 1, Rout = 0x00.
3. DIN = 0xA2 (add R0,R5):
   - T1: Rout = 0x01, Ain = 1.
   - T2: Rout = 0x20, Gin = 1, AddSub = 0.
   - T3: Gout = 1, Rin = 0x01, Done = 1.
4. DIN = 0xFF (sub R7,R7):
   - T1: Rout = 0x80, Ain = 1.
   - T2: Rout = 0x80, AddSub = 1.
   - T3: Rin = 0x80. Done pulses once.
5. Drop resetn during T2 of an add → Tstep = 0, Gin = 0, IR = 0x00 in the same cycle, before the next clock edge. With Run = 0 after release, all outputs stay 0.
6. PROC_CTRL_RUN_EDGE_EN defined, Run held at 1 for 20 cycles with DIN = 0x44 → exactly one Done pulse. Run 0 then 1 → a second Done pulse.
